// File: rtl/mem_bus_arbiter_if.sv
// Shared request/response types and the core/memory-facing bundle of the ibus/dbus arbiter.
// The slave modport is the arbiter's view; master is the view of the core and memory.
package mem_bus_arbiter_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    msize_t      mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_ok;
    logic [63:0] mresp_data;

    modport slave (
        input  ireq, dreq, mresp_ok, mresp_data,
        output iresp, dresp, mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

    modport master (
        output ireq, dreq, mresp_ok, mresp_data,
        input  iresp, dresp, mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between ibus and dbus,
// one outstanding transaction at a time, with a watchdog that force-completes hung accesses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    state_t             state_q, state_d;
    grant_t             last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               mreq_valid_q, mreq_valid_d;
    logic [63:0]        mreq_addr_q, mreq_addr_d;
    msize_t             mreq_size_q, mreq_size_d;
    logic [7:0]         mreq_strobe_q, mreq_strobe_d;
    logic [63:0]        mreq_data_q, mreq_data_d;
    ibus_resp_t         iresp_c;
    dbus_resp_t         dresp_c;

    logic grant_d, grant_i, timeout, done;
    logic [63:0] resp_data;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        mreq_valid_d  = mreq_valid_q;
        mreq_addr_d   = mreq_addr_q;
        mreq_size_d   = mreq_size_q;
        mreq_strobe_d = mreq_strobe_q;
        mreq_data_d   = mreq_data_q;
        iresp_c       = '0;
        dresp_c       = '0;

        // D wins a tie unless it was the last one served
        grant_d   = bus.dreq.valid && (!bus.ireq.valid || last_grant_q == GNT_I);
        grant_i   = bus.ireq.valid && !grant_d;
        timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        done      = bus.mresp_ok || timeout;
        resp_data = bus.mresp_ok ? bus.mresp_data : 64'h0;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d       = D_BUSY;
                    last_grant_d  = GNT_D;
                    cnt_d         = '0;
                    mreq_valid_d  = 1'b1;
                    mreq_addr_d   = bus.dreq.addr;
                    mreq_size_d   = bus.dreq.size;
                    mreq_strobe_d = bus.dreq.strobe;
                    mreq_data_d   = bus.dreq.data;
                end else if (grant_i) begin
                    state_d       = I_BUSY;
                    last_grant_d  = GNT_I;
                    cnt_d         = '0;
                    mreq_valid_d  = 1'b1;
                    mreq_addr_d   = bus.ireq.addr;
                    mreq_size_d   = MSIZE4;
                    mreq_strobe_d = 8'h0;
                    mreq_data_d   = 64'h0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (done) begin
                    if (state_q == I_BUSY) begin
                        iresp_c.addr_ok = 1'b1;
                        iresp_c.data_ok = 1'b1;
                        iresp_c.data    = resp_data;
                    end else begin
                        dresp_c.addr_ok = 1'b1;
                        dresp_c.data_ok = 1'b1;
                        dresp_c.data    = resp_data;
                    end
                    // A real completion on the timeout cycle is not an error
                    if (!bus.mresp_ok) err_d = 1'b1;
                    state_d      = IDLE;
                    mreq_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An aborted transaction must not leak a response during the reset cycle
        if (reset) begin
            iresp_c = '0;
            dresp_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_I;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            mreq_valid_q  <= 1'b0;
            mreq_addr_q   <= 64'h0;
            mreq_size_q   <= MSIZE1;
            mreq_strobe_q <= 8'h0;
            mreq_data_q   <= 64'h0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            mreq_valid_q  <= mreq_valid_d;
            mreq_addr_q   <= mreq_addr_d;
            mreq_size_q   <= mreq_size_d;
            mreq_strobe_q <= mreq_strobe_d;
            mreq_data_q   <= mreq_data_d;
        end
    end

    assign bus.iresp       = iresp_c;
    assign bus.dresp       = dresp_c;
    assign bus.mreq_valid  = mreq_valid_q;
    assign bus.mreq_addr   = mreq_addr_q;
    assign bus.mreq_size   = mreq_size_q;
    assign bus.mreq_strobe = mreq_strobe_q;
    assign bus.mreq_data   = mreq_data_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-vector bench for mem_bus_arbiter: each record gives one cycle's inputs and the
// outputs expected in that same cycle; hand sequences cover watchdog and reset corners.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int T = 8;

    typedef struct {
        logic rst; logic iv; logic [63:0] ia;
        logic dv; logic [63:0] da; logic [2:0] ds; logic [7:0] dst; logic [63:0] dd;
        logic mok; logic [63:0] md;
    } in_t;

    typedef struct {
        logic mv; logic chk_m; logic [63:0] ma; logic [2:0] ms; logic [7:0] mst; logic [63:0] md;
        logic iok; logic [63:0] id; logic dok; logic [63:0] dd; logic err;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    logic clk;
    logic reset;
    logic err;
    int   n_chk;
    int   n_fail;
    int   vidx;
    vec_t tbl[$];

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t vi(logic rst, logic iv, logic [63:0] ia, logic dv, logic [63:0] da,
                               logic [2:0] ds, logic [7:0] dst, logic [63:0] dd,
                               logic mok, logic [63:0] md);
        in_t r;
        r.rst = rst; r.iv = iv; r.ia = ia; r.dv = dv; r.da = da;
        r.ds = ds; r.dst = dst; r.dd = dd; r.mok = mok; r.md = md;
        return r;
    endfunction

    function automatic exp_t e_idle(logic e);
        exp_t r;
        r.mv = 1'b0; r.chk_m = 1'b0; r.ma = '0; r.ms = '0; r.mst = '0; r.md = '0;
        r.iok = 1'b0; r.id = '0; r.dok = 1'b0; r.dd = '0; r.err = e;
        return r;
    endfunction

    function automatic exp_t e_busy(logic [63:0] ma, logic [2:0] ms, logic [7:0] mst, logic [63:0] md,
                                    logic iok, logic [63:0] id, logic dok, logic [63:0] dd, logic e);
        exp_t r;
        r.mv = 1'b1; r.chk_m = 1'b1; r.ma = ma; r.ms = ms; r.mst = mst; r.md = md;
        r.iok = iok; r.id = id; r.dok = dok; r.dd = dd; r.err = e;
        return r;
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(vec_t t);
        reset               = t.i.rst;
        bus.ireq.valid      = t.i.iv;
        bus.ireq.addr       = t.i.ia;
        bus.dreq.valid      = t.i.dv;
        bus.dreq.addr       = t.i.da;
        bus.dreq.size       = msize_t'(t.i.ds);
        bus.dreq.strobe     = t.i.dst;
        bus.dreq.data       = t.i.dd;
        bus.mresp_ok        = t.i.mok;
        bus.mresp_data      = t.i.md;
        #1;
        chk("mreq_valid", vidx, 64'(bus.mreq_valid), 64'(t.e.mv));
        if (t.e.chk_m) begin
            chk("mreq_addr",   vidx, bus.mreq_addr,         t.e.ma);
            chk("mreq_size",   vidx, 64'(bus.mreq_size),    64'(t.e.ms));
            chk("mreq_strobe", vidx, 64'(bus.mreq_strobe),  64'(t.e.mst));
            chk("mreq_data",   vidx, bus.mreq_data,         t.e.md);
        end
        chk("iresp_addr_ok", vidx, 64'(bus.iresp.addr_ok), 64'(t.e.iok));
        chk("iresp_data_ok", vidx, 64'(bus.iresp.data_ok), 64'(t.e.iok));
        chk("iresp_data",    vidx, bus.iresp.data,         t.e.id);
        chk("dresp_addr_ok", vidx, 64'(bus.dresp.addr_ok), 64'(t.e.dok));
        chk("dresp_data_ok", vidx, 64'(bus.dresp.data_ok), 64'(t.e.dok));
        chk("dresp_data",    vidx, bus.dresp.data,         t.e.dd);
        chk("err",           vidx, 64'(err),               64'(t.e.err));
        vidx++;
        @(negedge clk);
    endtask

    localparam logic [63:0] IA  = 64'h8000_0000;
    localparam logic [63:0] IA4 = 64'h8000_0004;

    initial begin
        exp_t e_rst;
        n_chk = 0; n_fail = 0; vidx = 0;
        reset = 1'b1;
        bus.ireq = '0; bus.dreq = '0; bus.mresp_ok = 1'b0; bus.mresp_data = '0;
        repeat (2) @(negedge clk);

        // reset state: bus fields are zero too
        e_rst = e_idle(1'b0);
        e_rst.chk_m = 1'b1;
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_rst});
        // I read, ok on third busy cycle, then stray ok in IDLE
        tbl.push_back('{vi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0), e_busy(IA, 2, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{vi(0, 1, IA, 0, 0, 0, 0, 0, 0, 0), e_busy(IA, 2, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{vi(0, 1, IA, 0, 0, 0, 0, 0, 1, 64'h13), e_busy(IA, 2, 0, 0, 1, 64'h13, 0, 0, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h99), e_idle(0)});
        // reset restores last_grant=I, so contention grants D, I, D
        tbl.push_back('{vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 1, 64'h77),
                        e_busy(64'h1000, 3, 8'hFF, 64'hDEAD, 0, 0, 1, 64'h77, 0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 1, 64'h1111),
                        e_busy(IA4, 2, 0, 0, 1, 64'h1111, 0, 0, 0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 1, IA4, 1, 64'h1000, 3, 8'hFF, 64'hDEAD, 1, 64'h22),
                        e_busy(64'h1000, 3, 8'hFF, 64'hDEAD, 0, 0, 1, 64'h22, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});
        // D write whose request changes after the latch
        tbl.push_back('{vi(0, 0, 0, 1, 64'h2000, 2, 8'h0F, 64'hABCD, 0, 0), e_idle(0)});
        tbl.push_back('{vi(0, 0, 0, 1, 64'h3000, 3, 8'hF0, 64'h1234, 0, 0),
                        e_busy(64'h2000, 2, 8'h0F, 64'hABCD, 0, 0, 0, 0, 0)});
        tbl.push_back('{vi(0, 0, 0, 1, 64'h3000, 3, 8'hF0, 64'h1234, 0, 0),
                        e_busy(64'h2000, 2, 8'h0F, 64'hABCD, 0, 0, 0, 0, 0)});
        tbl.push_back('{vi(0, 0, 0, 1, 64'h3000, 3, 8'hF0, 64'h1234, 1, 64'h0),
                        e_busy(64'h2000, 2, 8'h0F, 64'hABCD, 0, 0, 1, 64'h0, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});

        foreach (tbl[k]) run_vec(tbl[k]);

        // ok arriving on the exact timeout cycle wins
        run_vec('{vi(0, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});
        for (int k = 1; k <= T; k++)
            run_vec('{vi(0, 1, 64'h100, 0, 0, 0, 0, 0, (k == T), 64'h55),
                      e_busy(64'h100, 2, 0, 0, (k == T), (k == T) ? 64'h55 : 64'h0, 0, 0, 0)});
        run_vec('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});

        // memory never answers: forced completion with zero data, sticky err
        run_vec('{vi(0, 1, 64'h200, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});
        for (int k = 1; k <= T; k++)
            run_vec('{vi(0, 1, 64'h200, 0, 0, 0, 0, 0, 0, 0),
                      e_busy(64'h200, 2, 0, 0, (k == T), 64'h0, 0, 0, 0)});
        run_vec('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(1)});
        run_vec('{vi(0, 0, 0, 1, 64'h40, 3, 0, 0, 0, 0), e_idle(1)});
        run_vec('{vi(0, 0, 0, 1, 64'h40, 3, 0, 0, 1, 64'hAB), e_busy(64'h40, 3, 0, 0, 0, 0, 1, 64'hAB, 1)});
        run_vec('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(1)});

        // reset during D_BUSY with ok in the reset cycle and the one after
        run_vec('{vi(0, 0, 0, 1, 64'h50, 3, 8'h03, 64'h77, 0, 0), e_idle(1)});
        run_vec('{vi(0, 0, 0, 1, 64'h50, 3, 8'h03, 64'h77, 0, 0), e_busy(64'h50, 3, 8'h03, 64'h77, 0, 0, 0, 0, 1)});
        run_vec('{vi(1, 0, 0, 1, 64'h50, 3, 8'h03, 64'h77, 1, 64'h99), e_busy(64'h50, 3, 8'h03, 64'h77, 0, 0, 0, 0, 1)});
        run_vec('{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h99), e_idle(0)});
        run_vec('{vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_idle(0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
